mon_dff: RTL and testbench
==========================

MON_DFF -- requirements
Module: mon_dff

Interface
REQ-001 The block SHALL have parameter ID, default 1, meaning the monitor instance number on the shared bench.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the capture FIFO depth in words (power of two, 2..16).
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 Port dout  input  1  serial bit sampled from the DUT output.
REQ-006 Port cap_en  input  1  capture enable from the bench control side.
REQ-007 Port flush  input  1  synchronous clear of capture state, FIFO and overflow status.
REQ-008 Port rd_req  input  1  one-cycle pop request from the reader side.
REQ-009 Port rd_data  output  32  popped word, LSB = first captured bit.
REQ-010 Port rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-011 Port word_cnt  output  5  current FIFO occupancy, 0..DEPTH.
REQ-012 Port ovf  output  1  sticky flag: at least one completed word dropped.
REQ-013 Port ovf_cnt  output  16  count of dropped words, saturating at 16'hFFFF.

Function
REQ-014 The block SHALL implement states IDLE, WAIT_SYNC, CAPT.
REQ-015 IDLE -> WAIT_SYNC on a cycle with cap_en=1.
REQ-016 WAIT_SYNC -> CAPT on the first cycle with cap_en=1 and dout=1; that sync bit SHALL NOT be stored.
REQ-017 In CAPT each cycle SHALL shift dout into bit position bit_cnt (0..31) of the assembly register and increment bit_cnt.
REQ-018 On the cycle bit_cnt=31 is written, the completed word SHALL be pushed to the FIFO and bit_cnt SHALL wrap to 0; capture continues without a new sync bit.
REQ-019 cap_en=0 in WAIT_SYNC or CAPT SHALL return to IDLE the next cycle, discard the partial word and clear bit_cnt.
REQ-020 A push with the FIFO full and no same-cycle pop SHALL drop the word, set ovf, and increment ovf_cnt (saturating).
REQ-021 Simultaneous push and pop with the FIFO full SHALL accept both; occupancy unchanged, no overflow.
REQ-022 rd_req with word_cnt>0 SHALL pop the oldest word; rd_data and rd_valid=1 SHALL be presented the following cycle (latency 1).
REQ-023 rd_req with word_cnt=0 SHALL be ignored; rd_valid stays 0, rd_data holds its last value.
REQ-024 rd_valid SHALL be high for exactly one cycle per accepted pop; back-to-back rd_req SHALL yield back-to-back pops.
REQ-025 word_cnt SHALL reflect a push/pop on the cycle after the edge that performs it.
REQ-026 flush=1 SHALL, on that edge, empty the FIFO, clear ovf, ovf_cnt, bit_cnt and force IDLE; flush overrides cap_en, push and rd_req in the same cycle (no rd_valid results).

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, bit_cnt=0, FIFO empty, rd_data=0, rd_valid=0, word_cnt=0, ovf=0, ovf_cnt=0.
REQ-028 Reset asserted mid-word or mid-pop SHALL discard all captured data with no rd_valid produced.
REQ-029 Release of rst SHALL take effect on the first rising clk edge after rst returns high.

Structure
REQ-030 State enum (IDLE, WAIT_SYNC, CAPT), word width 32 and the uint32_t typedef SHALL live in the shared bench package.
REQ-031 The FIFO SHALL be a separate sub-module mon_fifo (parameter DEPTH, 32-bit data, push/pop/count/full/empty).
REQ-032 Pointers SHALL be log2(DEPTH) bits wrapping naturally; full/empty derived from an occupancy counter.

Verification
REQ-033 Reset: rst=0 for 25 ns with dout toggling -> all outputs 0, state IDLE.
REQ-034 Single word: cap_en=1, dout=1 sync then bits 32'hA5A5_0F0F LSB-first, then rd_req -> rd_valid one cycle later with rd_data=32'hA5A5_0F0F, word_cnt 1->0.
REQ-035 Overflow: DEPTH=8, capture 10 words without reads -> word_cnt=8, ovf=1, ovf_cnt=2; reads return words 1..8 in order.
REQ-036 Full push+pop: FIFO full, rd_req on the completion cycle of word 9 -> word_cnt stays 8, ovf=0, word 9 later read out.
REQ-037 Abort: cap_en dropped after 12 bits of a word, re-enabled with new sync and word 32'h0000_0001 -> only 32'h0000_0001 read, no partial word.
REQ-038 Empty read and flush: rd_req at word_cnt=0 -> rd_valid stays 0; flush with 3 words queued and ovf=1 -> word_cnt=0, ovf=0, ovf_cnt=0 next cycle.

Source files
------------

// File: rtl/mon_dff_pkg.sv
// rtl/mon_dff_pkg.sv - shared types for the serial capture monitor
package mon_dff_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] uint32_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        CAPT      = 2'd2
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'd31;
endpackage

// File: rtl/mon_dff_fifo.sv
// rtl/mon_dff_fifo.sv - capture word FIFO with occupancy counter
module mon_fifo
    import mon_dff_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  uint32_t    push_data,
    input  logic       pop,
    output uint32_t    pop_data,
    output logic [4:0] count,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    uint32_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]     count_q, count_d;
    logic           push_ok, pop_ok;

    assign full     = (count_q == 5'(DEPTH));
    assign empty    = (count_q == 5'd0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when a pop frees the slot on the same edge.
    assign pop_ok   = pop && !empty && !flush;
    assign push_ok  = push && (!full || pop_ok) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/mon_dff.sv
// rtl/mon_dff.sv - serial bit monitor: sync detect, 32-bit word assembly, FIFO readout
module mon_dff
    import mon_dff_pkg::*;
#(
    parameter int ID    = 1,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dout,
    input  logic        cap_en,
    input  logic        flush,
    input  logic        rd_req,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [4:0]  word_cnt,
    output logic        ovf,
    output logic [15:0] ovf_cnt
);
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    uint32_t     asm_q, asm_d;
    uint32_t     rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        ovf_q, ovf_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic        push, pop;
    uint32_t     fifo_data;
    logic        fifo_full, fifo_empty;

    mon_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (asm_d),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (word_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        asm_d      = asm_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        ovf_cnt_d  = ovf_cnt_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (flush) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap_en) state_d = WAIT_SYNC;
                end
                WAIT_SYNC: begin
                    if (!cap_en) begin
                        state_d = IDLE;
                    end else if (dout) begin
                        state_d   = CAPT;
                        bit_cnt_d = '0;
                    end
                end
                CAPT: begin
                    if (!cap_en) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        // asm_d carries the final bit so the pushed word is complete this cycle.
                        asm_d[bit_cnt_q] = dout;
                        bit_cnt_d        = bit_cnt_q + 5'd1;
                        push             = (bit_cnt_q == LAST_BIT);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase

            pop = rd_req && !fifo_empty;
            if (pop) begin
                rd_valid_d = 1'b1;
                rd_data_d  = fifo_data;
            end
            if (push && fifo_full && !pop) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            asm_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            asm_q      <= asm_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_q;
    assign ovf_cnt  = ovf_cnt_q;
endmodule

// File: tb/tb_mon_dff.sv
// tb/tb_mon_dff.sv - scoreboard bench for the serial capture monitor
module tb_mon_dff;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dout = 1'b0;
    logic        cap_en = 1'b0;
    logic        flush = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [4:0]  word_cnt;
    logic        ovf;
    logic [15:0] ovf_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mq[$];
    logic [31:0] last_rd = 32'h0;
    logic        exp_ovf = 1'b0;
    logic [15:0] exp_ovf_cnt = 16'h0;

    localparam int DEPTH = 8;

    mon_dff #(.ID(1), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .dout     (dout),
        .cap_en   (cap_en),
        .flush    (flush),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .word_cnt (word_cnt),
        .ovf      (ovf),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_start();
        cap_en = 1'b1;
        dout   = 1'b0;
        cyc();
        dout   = 1'b1;
        cyc();
    endtask

    task automatic capture_word(input logic [31:0] w, input bit pop_last);
        logic [31:0] exp_pop;
        bit          do_pop;
        exp_pop = 32'h0;
        for (int i = 0; i < 32; i++) begin
            dout = w[i];
            if (i == 31 && pop_last) rd_req = 1'b1;
            cyc();
        end
        rd_req = 1'b0;
        do_pop = pop_last && (mq.size() > 0);
        if (do_pop) exp_pop = mq.pop_front();
        if (mq.size() < DEPTH) begin
            mq.push_back(w);
        end else begin
            exp_ovf = 1'b1;
            if (exp_ovf_cnt != 16'hFFFF) exp_ovf_cnt++;
        end
        if (pop_last) begin
            vectors++;
            if (rd_valid !== do_pop) begin
                miscompares++;
                $display("FAIL push_pop_valid: got %b want %b", rd_valid, do_pop);
            end
            if (do_pop) begin
                vectors++;
                if (rd_data !== exp_pop) begin
                    miscompares++;
                    $display("FAIL push_pop_data: got %h want %h", rd_data, exp_pop);
                end
                last_rd = exp_pop;
            end
        end
    endtask

    task automatic read_burst(input int n);
        logic [31:0] exp;
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (i == n - 1) rd_req = 1'b0;
            exp = (mq.size() > 0) ? mq.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                miscompares++;
                $display("FAIL read_word%0d: got valid=%b data=%h want valid=1 data=%h", i, rd_valid, rd_data, exp);
            end
            last_rd = exp;
        end
        cyc();
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_valid_drop: got %b want 0", rd_valid);
        end
        vectors++;
        if (word_cnt !== 5'(mq.size())) begin
            miscompares++;
            $display("FAIL read_word_cnt: got %0d want %0d", word_cnt, mq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #5 dout = ~dout;
        end
        vectors++;
        if ({rd_data, rd_valid, word_cnt, ovf, ovf_cnt} !== 55'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h v=%b cnt=%0d ovf=%b ovfc=%0d want all 0",
                     rd_data, rd_valid, word_cnt, ovf, ovf_cnt);
        end
        @(negedge clk);
        rst  = 1'b1;
        dout = 1'b0;
        cyc();
        vectors++;
        if ({rd_valid, word_cnt, ovf} !== 7'h0) begin
            miscompares++;
            $display("FAIL reset_release: got v=%b cnt=%0d ovf=%b want 0", rd_valid, word_cnt, ovf);
        end
    endtask

    task automatic test_single_word();
        sync_start();
        capture_word(32'hA5A5_0F0F, 1'b0);
        cap_en = 1'b0;
        vectors++;
        if (word_cnt !== 5'd1) begin
            miscompares++;
            $display("FAIL single_cnt: got %0d want 1", word_cnt);
        end
        cyc();
        read_burst(1);
    endtask

    task automatic test_empty_read();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
            miscompares++;
            $display("FAIL empty_read: got v=%b data=%h want v=0 data=%h", rd_valid, rd_data, last_rd);
        end
    endtask

    task automatic test_overflow();
        sync_start();
        for (int i = 1; i <= 10; i++) capture_word(32'h1111_1111 * i, 1'b0);
        cap_en = 1'b0;
        vectors++;
        if (word_cnt !== 5'd8 || ovf !== 1'b1 || ovf_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL overflow_status: got cnt=%0d ovf=%b ovfc=%0d want 8 1 2", word_cnt, ovf, ovf_cnt);
        end
        vectors++;
        if (ovf !== exp_ovf || ovf_cnt !== exp_ovf_cnt) begin
            miscompares++;
            $display("FAIL overflow_model: got ovf=%b ovfc=%0d want %b %0d", ovf, ovf_cnt, exp_ovf, exp_ovf_cnt);
        end
        cyc();
        read_burst(8);
    endtask

    task automatic test_flush();
        sync_start();
        for (int i = 0; i < 3; i++) capture_word(32'hF00D_0000 | i, 1'b0);
        cap_en = 1'b0;
        cyc();
        vectors++;
        if (word_cnt !== 5'd3 || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre: got cnt=%0d ovf=%b want 3 1", word_cnt, ovf);
        end
        flush  = 1'b1;
        rd_req = 1'b1;
        cyc();
        flush  = 1'b0;
        rd_req = 1'b0;
        mq.delete();
        exp_ovf     = 1'b0;
        exp_ovf_cnt = 16'h0;
        vectors++;
        if (word_cnt !== 5'd0 || ovf !== 1'b0 || ovf_cnt !== 16'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_post: got cnt=%0d ovf=%b ovfc=%0d v=%b want 0 0 0 0",
                     word_cnt, ovf, ovf_cnt, rd_valid);
        end
    endtask

    task automatic test_full_push_pop();
        sync_start();
        for (int i = 1; i <= 8; i++) capture_word(32'h0F0F_0000 + 32'(i * 3), 1'b0);
        capture_word(32'h9999_0009, 1'b1);
        cap_en = 1'b0;
        vectors++;
        if (word_cnt !== 5'd8 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL full_push_pop: got cnt=%0d ovf=%b want 8 0", word_cnt, ovf);
        end
        cyc();
        read_burst(8);
    endtask

    task automatic test_abort();
        sync_start();
        for (int i = 0; i < 12; i++) begin
            dout = 1'b1;
            cyc();
        end
        cap_en = 1'b0;
        cyc();
        sync_start();
        capture_word(32'h0000_0001, 1'b0);
        cap_en = 1'b0;
        cyc();
        vectors++;
        if (word_cnt !== 5'd1) begin
            miscompares++;
            $display("FAIL abort_cnt: got %0d want 1", word_cnt);
        end
        read_burst(1);
    endtask

    task automatic test_reset_midword();
        sync_start();
        capture_word(32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            dout = i[0];
            cyc();
        end
        rd_req = 1'b1;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (word_cnt !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL midword_reset: got cnt=%0d v=%b data=%h want 0 0 0", word_cnt, rd_valid, rd_data);
        end
        cyc();
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midword_reset_valid: got %b want 0", rd_valid);
        end
        @(negedge clk);
        rst    = 1'b1;
        rd_req = 1'b0;
        cap_en = 1'b0;
        mq.delete();
        last_rd = 32'h0;
        cyc();
        test_empty_read();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_empty_read();
        test_overflow();
        test_flush();
        test_full_push_pop();
        test_abort();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
